// File: rtl/alu_share_pkg.sv
// Shared-ALU arbiter package: FSM state encoding and ALU op-code constants.
// No ports; imported by alu_share_arbiter.
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } share_state_e;

  // Highest op code the shared ALU implements
  localparam logic [3:0] ALU_OP_MAX = 4'd10;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_PASSB = 4'd10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  PTR_W    index holding highest priority this cycle
//   grant out NUM_REQ  one-hot grant (zero when no request)
// The first set bit found scanning ptr, ptr+1, ... (mod NUM_REQ) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    logic w_found;
    int   w_idx;
    grant   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(ptr) + k) % NUM_REQ;
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters.
// A request is granted round-robin, its op/operands are registered onto the
// ALU inputs, the ALU result is captured one cycle later and held on the
// owner's response channel until that owner accepts it.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   per-requester request handshake
//   req_op/req_a/req_b    flattened per-requester op and operands
//   rsp_valid/rsp_ready   per-requester response handshake (rsp_valid one-hot)
//   rsp_data, rsp_err     shared result and illegal-op flag
//   alu_op, operand_a/b   registered drive to the shared ALU
//   alu_data              result from the shared ALU
//
// Build option: define ALU_SHARE_OPCHECK_EN to replace the result of op codes
// above ALU_OP_MAX with zero and raise rsp_err. Otherwise rsp_err is tied low.
//
// state | meaning
// IDLE  | arbitrating; req_ready to the round-robin winner
// EXEC  | ALU driven from latched registers; result captured at end of cycle
// RESP  | result held on owner's channel until rsp_ready[owner]
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [OP_W-1:0]           alu_op,
  output logic [DATA_W-1:0]         operand_a,
  output logic [DATA_W-1:0]         operand_b,
  input  logic [DATA_W-1:0]         alu_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  share_state_e        r_state, w_state_nxt;
  logic [PTR_W-1:0]    r_rr_ptr, r_owner, w_grant_idx, w_ptr_nxt;
  logic [NUM_REQ-1:0]  w_grant, r_rsp_valid;
  logic [OP_W-1:0]     r_alu_op;
  logic [DATA_W-1:0]   r_operand_a, r_operand_b, r_rsp_data;
  logic                w_accept, w_rsp_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant)
  );

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_grant_idx = PTR_W'(i);
    end
  end

  // Explicit wrap so non-power-of-two NUM_REQ stays in range
  assign w_ptr_nxt = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = w_grant;
        if (|(req_valid & w_grant)) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        if (rsp_ready[r_owner]) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef ALU_SHARE_OPCHECK_EN
  logic r_rsp_err;
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_alu_op    <= '0;
      r_operand_a <= '0;
      r_operand_b <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= '0;
`ifdef ALU_SHARE_OPCHECK_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      // ALU input registers only load on accept; they hold otherwise
      if (w_accept) begin
        r_alu_op    <= req_op[w_grant_idx*OP_W +: OP_W];
        r_operand_a <= req_a[w_grant_idx*DATA_W +: DATA_W];
        r_operand_b <= req_b[w_grant_idx*DATA_W +: DATA_W];
        r_owner     <= w_grant_idx;
        r_rr_ptr    <= w_ptr_nxt;
      end
      if (r_state == EXEC) begin
        r_rsp_valid          <= '0;
        r_rsp_valid[r_owner] <= 1'b1;
`ifdef ALU_SHARE_OPCHECK_EN
        if (r_alu_op > OP_W'(ALU_OP_MAX)) begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
        end else begin
          r_rsp_data <= alu_data;
          r_rsp_err  <= 1'b0;
        end
`else
        r_rsp_data <= alu_data;
`endif
      end
      if (w_rsp_done) r_rsp_valid <= '0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign alu_op    = r_alu_op;
  assign operand_a = r_operand_a;
  assign operand_b = r_operand_b;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [31:0] rsp_data, operand_a, operand_b, alu_data;
  logic        rsp_err;
  logic [3:0]  alu_op;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(2), .DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b),
    .alu_data(alu_data)
  );

  // External shared ALU
  always_comb begin
    case (alu_op)
      4'd0:    alu_data = operand_a + operand_b;
      4'd1:    alu_data = operand_a - operand_b;
      4'd2:    alu_data = operand_a & operand_b;
      4'd3:    alu_data = {31'b0, $signed(operand_a) < $signed(operand_b)};
      4'd4:    alu_data = {31'b0, operand_a < operand_b};
      4'd5:    alu_data = operand_a ^ operand_b;
      4'd10:   alu_data = operand_b;
      default: alu_data = 32'h0;
    endcase
  end

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [31:0] data, input logic err);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    e.err  = err;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per response handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && ((rsp_valid & rsp_ready) != 2'b00)) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp actual=%b expected=none", rsp_valid);
        end else begin
          e = q.pop_front();
          chk("rsp_owner", 32'(rsp_valid), 32'(1 << e.idx));
          chk("rsp_data",  rsp_data, e.data);
          chk("rsp_err",   32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[i*4 +: 4]   = op;
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
    req_valid[i]       = 1'b1;
  endtask

  // Returns at negedge+1 of the cycle in which req_ready[i] is high
  task automatic wait_ready(input int i);
    bit ok;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[i]) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL ready_timeout req=%0d actual=0 expected=1", i);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && rsp_valid == 2'b00) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d expected=0", q.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data",  rsp_data, 32'h0);
    chk("reset_rsp_err",   32'(rsp_err), 32'h0);
    chk("reset_alu_op",    32'(alu_op), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single add with latency check
    set_req(0, 4'd0, 32'd5, 32'd7);
    #1;
    chk("add_ready_same_cycle", 32'(req_ready), 32'h1);
    push_exp(0, 32'd12, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("add_no_rsp_in_exec", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("add_rsp_after_two", 32'(rsp_valid), 32'h1);
    drain();

    // Signed and unsigned compare on requester 1
    set_req(1, 4'd3, 32'hFFFF_FFFF, 32'd1);
    wait_ready(1);
    push_exp(1, 32'd1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("slt_alu_op_latched", 32'(alu_op), 32'd3);
    chk("slt_operand_a",      operand_a, 32'hFFFF_FFFF);
    @(negedge clk);
    set_req(1, 4'd4, 32'hFFFF_FFFF, 32'd1);
    wait_ready(1);
    push_exp(1, 32'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    drain();

    // Contention: both valid, expect alternating grants starting at 0
    set_req(0, 4'd0, 32'd1, 32'd2);
    set_req(1, 4'd5, 32'hF0, 32'hFF);
    for (int k = 0; k < 4; k++) begin
      int exp_i;
      exp_i = k % 2;
      wait_ready(exp_i);
      chk("contention_grant", 32'(req_ready), 32'(1 << exp_i));
      push_exp(exp_i, (exp_i == 0) ? 32'd3 : 32'h0F, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 2'b00;
    drain();

    // Backpressure on requester 0 while requester 1 waits
    rsp_ready[0] = 1'b0;
    set_req(0, 4'd1, 32'd10, 32'd3);
    wait_ready(0);
    push_exp(0, 32'd7, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    set_req(1, 4'd0, 32'd100, 32'd23);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_rsp_valid_held", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_data_held",  rsp_data, 32'd7);
      chk("bp_req_ready_low",  32'(req_ready), 32'h0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_released_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("bp_released_grant1",    32'(req_ready), 32'h2);
    push_exp(1, 32'd123, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    drain();

    // Reset during EXEC: no response, pointer back to 0
    set_req(0, 4'd1, 32'd9, 32'd4);
    wait_ready(0);
    @(posedge clk);
    #2;
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_alu_op",    32'(alu_op), 32'h0);
    chk("rst_operand_a", operand_a, 32'h0);
    chk("rst_operand_b", operand_b, 32'h0);
    chk("rst_rsp_data",  rsp_data, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    set_req(0, 4'd5, 32'd3, 32'd5);
    set_req(1, 4'd10, 32'd0, 32'h55);
    #1;
    chk("post_rst_grant0", 32'(req_ready), 32'h1);
    push_exp(0, 32'd6, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    drain();

    // Illegal op code
    set_req(0, 4'd12, 32'd1, 32'd1);
    wait_ready(0);
`ifdef ALU_SHARE_OPCHECK_EN
    push_exp(0, 32'd0, 1'b1);
`else
    push_exp(0, 32'd0, 1'b0);
`endif
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    drain();

    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
